// File: rtl/noc_output_scheduler_if.sv
// Scheduler-side bundle for one router output port: input VC requests and credit
// returns toward the scheduler, the grant and credit/lock state back to the sender side.
interface noc_output_scheduler_if #(
  parameter int PORTS        = 5,
  parameter int VC_COUNT     = 3,
  parameter int BUFFER_DEPTH = 4
);
  localparam int CW = $clog2(BUFFER_DEPTH + 1);

  logic [PORTS-1:0][VC_COUNT-1:0] req;
  logic [PORTS-1:0][VC_COUNT-1:0] req_head;
  logic [PORTS-1:0][VC_COUNT-1:0] req_tail;
  logic [VC_COUNT-1:0]            credit_return;
  logic [PORTS-1:0][VC_COUNT-1:0] grant;
  logic                           grant_valid;
  logic [VC_COUNT-1:0][CW-1:0]    credit_count;
  logic [VC_COUNT-1:0]            vc_locked;
  logic                           credit_overflow;

  modport master (
    output req, req_head, req_tail, credit_return,
    input  grant, grant_valid, credit_count, vc_locked, credit_overflow
  );

  modport slave (
    input  req, req_head, req_tail, credit_return,
    output grant, grant_valid, credit_count, vc_locked, credit_overflow
  );
endinterface

// File: rtl/noc_output_scheduler.sv
// Output-port switch scheduler: round-robin over flattened (port,VC) requests with
// wormhole VC ownership and per-VC downstream credit tracking.
module noc_output_scheduler #(
  parameter int PORTS        = 5,
  parameter int VC_COUNT     = 3,
  parameter int BUFFER_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  noc_output_scheduler_if.slave bus
);
  localparam int N   = PORTS * VC_COUNT;
  localparam int CW  = $clog2(BUFFER_DEPTH + 1);
  localparam int CW1 = CW + 1;
  localparam int PW  = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int IW  = (N > 1) ? $clog2(N) : 1;
  localparam int IW1 = IW + 1;

  typedef enum logic {LK_IDLE = 1'b0, LK_LOCKED = 1'b1} lock_e;

  lock_e               r_lock      [VC_COUNT];
  logic [PW-1:0]       r_owner     [VC_COUNT];
  logic [CW-1:0]       r_cnt       [VC_COUNT];
  logic [IW-1:0]       r_rr_ptr;
  logic                r_overflow;

  lock_e               w_lock_nxt  [VC_COUNT];
  logic [PW-1:0]       w_owner_nxt [VC_COUNT];
  logic [CW-1:0]       w_cnt_nxt   [VC_COUNT];
  logic [IW-1:0]       w_rr_nxt;
  logic                w_overflow_nxt;

  logic [N-1:0]        w_elig;
  logic [N-1:0]        w_grant;
  logic                w_found;
  logic [IW-1:0]       w_win;
  logic [VC_COUNT-1:0] w_gnt_vc;
  logic [PW-1:0]       w_gnt_port;
  logic                w_gnt_tail;

  // Eligibility: an idle VC accepts only heads, a locked VC only its owner (head ignored).
  always_comb begin
    w_elig = '0;
    for (int p = 0; p < PORTS; p++) begin
      for (int v = 0; v < VC_COUNT; v++) begin
        if (bus.req[p][v] && (r_cnt[v] != CW'(0))) begin
          if (r_lock[v] == LK_IDLE) begin
            w_elig[p*VC_COUNT+v] = bus.req_head[p][v];
          end else begin
            w_elig[p*VC_COUNT+v] = (r_owner[v] == PW'(p));
          end
        end else begin
          w_elig[p*VC_COUNT+v] = 1'b0;
        end
      end
    end
  end

  // Round-robin search starting at r_rr_ptr, wrapping modulo N.
  always_comb begin
    logic [IW:0] cand;
    cand    = '0;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, r_rr_ptr} + IW1'(k);
      if (cand >= IW1'(N)) begin
        cand = cand - IW1'(N);
      end else begin
        cand = cand;
      end
      if (!w_found && w_elig[cand[IW-1:0]]) begin
        w_found = 1'b1;
        w_win   = cand[IW-1:0];
      end else begin
        w_found = w_found;
      end
    end
  end

  // One-hot grant, suppressed while reset is asserted.
  always_comb begin
    w_grant = '0;
    if (w_found && !reset) begin
      w_grant[w_win] = 1'b1;
    end else begin
      w_grant = '0;
    end
  end

  // Decode the winner back to its VC, port and tail flag.
  always_comb begin
    w_gnt_vc   = '0;
    w_gnt_port = '0;
    w_gnt_tail = 1'b0;
    for (int p = 0; p < PORTS; p++) begin
      for (int v = 0; v < VC_COUNT; v++) begin
        if (w_grant[p*VC_COUNT+v]) begin
          w_gnt_vc[v] = 1'b1;
          w_gnt_port  = PW'(p);
          w_gnt_tail  = bus.req_tail[p][v];
        end else begin
          w_gnt_vc[v] = w_gnt_vc[v];
        end
      end
    end
  end

  // Next state: pointer advance, per-VC lock FSM and credit arithmetic.
  always_comb begin
    logic [CW:0] sum;
    sum            = '0;
    w_overflow_nxt = r_overflow;
    w_rr_nxt       = r_rr_ptr;
    if (w_found && !reset) begin
      w_rr_nxt = (w_win == IW'(N - 1)) ? IW'(0) : (w_win + IW'(1));
    end else begin
      w_rr_nxt = r_rr_ptr;
    end
    for (int v = 0; v < VC_COUNT; v++) begin
      w_lock_nxt[v]  = r_lock[v];
      w_owner_nxt[v] = r_owner[v];
      w_cnt_nxt[v]   = r_cnt[v];
      case (r_lock[v])
        LK_IDLE: begin
          // Any grant on an idle VC is a head; a head without tail opens the worm.
          if (w_gnt_vc[v] && !w_gnt_tail) begin
            w_lock_nxt[v]  = LK_LOCKED;
            w_owner_nxt[v] = w_gnt_port;
          end else begin
            w_lock_nxt[v] = LK_IDLE;
          end
        end
        LK_LOCKED: begin
          if (w_gnt_vc[v] && w_gnt_tail) begin
            w_lock_nxt[v] = LK_IDLE;
          end else begin
            w_lock_nxt[v] = LK_LOCKED;
          end
        end
        default: begin
          w_lock_nxt[v] = LK_IDLE;
        end
      endcase
      sum = {1'b0, r_cnt[v]} - CW1'(w_gnt_vc[v]) + CW1'(bus.credit_return[v]);
      if (sum > CW1'(BUFFER_DEPTH)) begin
        w_overflow_nxt = 1'b1;
      end else begin
        w_cnt_nxt[v] = sum[CW-1:0];
      end
    end
  end

  // State registers with synchronous reset; in-flight packets are abandoned.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr   <= '0;
      r_overflow <= 1'b0;
      for (int v = 0; v < VC_COUNT; v++) begin
        r_lock[v]  <= LK_IDLE;
        r_owner[v] <= '0;
        r_cnt[v]   <= CW'(BUFFER_DEPTH);
      end
    end else begin
      r_rr_ptr   <= w_rr_nxt;
      r_overflow <= w_overflow_nxt;
      for (int v = 0; v < VC_COUNT; v++) begin
        r_lock[v]  <= w_lock_nxt[v];
        r_owner[v] <= w_owner_nxt[v];
        r_cnt[v]   <= w_cnt_nxt[v];
      end
    end
  end

  // Outputs: grant is combinational; status outputs come straight from registers.
  always_comb begin
    bus.grant           = w_grant;
    bus.grant_valid     = |w_grant;
    bus.credit_overflow = r_overflow;
    bus.vc_locked       = '0;
    bus.credit_count    = '0;
    for (int v = 0; v < VC_COUNT; v++) begin
      bus.vc_locked[v]    = (r_lock[v] == LK_LOCKED);
      bus.credit_count[v] = r_cnt[v];
    end
  end
endmodule

// File: doc/noc_output_scheduler.md
# noc_output_scheduler

Per-output-port switch scheduler for the mesh router: decides each cycle which input port/VC pair may send one flit onto a single output link. It enforces wormhole ownership of each downstream VC from head to tail flit and tracks downstream buffer credits per VC. It is instantiated once per router output port (N/E/S/W/LOCAL), sitting between the input VC buffers and the output link mux.

## Interface
Parameters:
- PORTS, 5, number of input ports competing for this output
- VC_COUNT, 3, virtual channels per link; a flit keeps its VC index through the router
- BUFFER_DEPTH, 4, flit slots per VC in the downstream input buffer (initial credits)

Ports (CW = $clog2(BUFFER_DEPTH+1)):
- One clock; reset is synchronous and active-high.
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req  in  [PORTS-1:0][VC_COUNT-1:0]  input p, VC v has a flit for this output on VC v
- req_head  in  [PORTS-1:0][VC_COUNT-1:0]  presented flit is a head flit
- req_tail  in  [PORTS-1:0][VC_COUNT-1:0]  presented flit is a tail flit (head+tail = single-flit packet)
- credit_return  in  [VC_COUNT-1:0]  downstream freed one slot on VC v this cycle
- grant  out  [PORTS-1:0][VC_COUNT-1:0]  at most one bit set; flit transfers this cycle
- grant_valid  out  1  OR of grant
- credit_count  out  [VC_COUNT-1:0][CW-1:0]  current credits per VC
- vc_locked  out  [VC_COUNT-1:0]  VC v owned by a packet in flight
- credit_overflow  out  1  sticky error: credit returned while count already BUFFER_DEPTH

## Operation
- State per VC v: lock[v] (IDLE/LOCKED), owner[v] (port index), cnt[v] (0..BUFFER_DEPTH). Global rr_ptr over N = PORTS*VC_COUNT flattened indices, i = p*VC_COUNT + v.
- Eligible(p,v) = req[p][v] && cnt[v] != 0 && (lock[v]==IDLE ? req_head[p][v] : owner[v]==p).
- While LOCKED, req_head from the owner is ignored (treated as body); non-owner requests on that VC are never eligible.
- Arbitration: winner = first eligible index scanning i = rr_ptr, rr_ptr+1, ... modulo N. No eligible -> no grant.
- On grant to (p,v): rr_ptr <= (i+1) mod N; otherwise rr_ptr holds.
- Lock transitions on grant: IDLE + head && !tail -> LOCKED, owner=p. LOCKED + tail -> IDLE. IDLE + head && tail -> stays IDLE. LOCKED + !tail -> stays LOCKED.
- Credits: cnt[v] next = cnt[v] - grant_on_v + credit_return[v], computed in CW+1 bits.
  - Grant and return on the same VC in the same cycle -> unchanged.
  - Return while cnt==BUFFER_DEPTH with no grant on v -> cnt holds, credit_overflow <= 1 (sticky until reset).
  - cnt==0 -> VC v ineligible. Underflow is impossible by construction.
- Requesters may drop req without a grant; lock/owner are unaffected.

## Timing
- grant/grant_valid are combinational from req, req_head, req_tail and registered state in the same cycle. Zero-cycle decision; the flit moves in the grant cycle.
- lock, owner, cnt and rr_ptr update on the clk edge ending the grant cycle. A returned credit is usable the cycle after credit_return.
- vc_locked, credit_count and credit_overflow are register outputs.
- Reset (any cycle, including mid-packet): lock=IDLE for all VCs, owner=0, cnt=BUFFER_DEPTH, rr_ptr=0, credit_overflow=0. grant and grant_valid are forced to 0 while reset is high. Packets in flight are abandoned.
- Throughput: one flit per cycle per output when credits allow.

## Test plan
- Reset then single flit: req[1][0]=1, head=tail=1 -> grant[1][0] same cycle; next cycle cnt[0]=3, vc_locked[0]=0.
- Wormhole lock: port 0 VC 2 head (no tail) granted; then port 3 VC 2 head requests while port 0 sends body, then tail -> port 3 never granted until the cycle after port 0's tail grant; vc_locked[2] high for exactly those cycles.
- Round robin: all 15 req with head=tail=1 and credit_return every cycle on all VCs -> grants cycle through flattened indices 0,1,...,14,0 in order.
- Credit exhaustion: 4 grants on VC 1 with no returns -> cnt[1]=0 and VC 1 ineligible. One credit_return -> grant resumes the following cycle. Simultaneous grant+return -> cnt unchanged.
- Overflow: credit_return[0] at cnt[0]=4 -> cnt stays 4; credit_overflow=1 and stays 1 until reset.
- Reset mid-packet: reset asserted with VC 0 LOCKED and cnt[0]=1 -> next cycle IDLE, cnt=4, no grant during the reset cycle; a non-head body req is ignored afterwards.
